// File: rtl/arb_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // First set request bit scanning upward from ptr, wrapping 7 -> 0.
    // Returns ptr when no request is set (caller only uses it when req != 0).
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req_vec,
                                                 input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] idx;
        logic            found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ptr + ID_W'(i);
            if (!found && req_vec[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/onehot_enc8.sv
// One-hot to binary index encoder; an all-zero input encodes as index 0.
module onehot_enc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_onehot,
    output logic [ID_W-1:0]  o_index
);

    // OR together the indices of set bits; exact for one-hot or zero input.
    always_comb begin
        o_index = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (i_onehot[i]) begin
                o_index = o_index | ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/arbiter_8req.sv
// Round-robin arbiter for 8 requesters with IDLE/GRANT/RELEASE sequencing.
// Optional forced revocation after MAX_HOLD grant cycles: define ARB_TIMEOUT_EN.
module arbiter_8req
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
        $error("arbiter_8req: MAX_HOLD must be in 2..255");
    end

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_ptr_next;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_next;
    logic [ID_W-1:0]  r_gnt_id;
    logic [ID_W-1:0]  w_gnt_id_next;
    logic             r_gnt_valid;
    logic             r_timeout;
    logic             w_timeout_next;
    logic [ID_W-1:0]  w_winner;
    logic             w_release;

`ifdef ARB_TIMEOUT_EN
    logic [7:0]       r_hold;
    logic [7:0]       w_hold_next;
    logic [7:0]       w_hold_inc;
    assign w_hold_inc = r_hold + 8'd1;
`endif

    assign w_winner  = rr_pick(req, r_ptr);
    assign w_release = done || !req[r_gnt_id];

    // Index of the grant being registered, so gnt_id always matches gnt.
    onehot_enc8 u_enc (
        .i_onehot (w_gnt_next),
        .o_index  (w_gnt_id_next)
    );

    // Next-state, next-pointer and next registered-output logic.
    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_gnt_next     = r_gnt;
        w_timeout_next = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_hold_next    = r_hold;
`endif
        case (r_state)
            IDLE: begin
                w_gnt_next = '0;
                if (|req) begin
                    w_state_next = GRANT;
                    w_gnt_next   = N_REQ'(1) << w_winner;
                    w_ptr_next   = w_winner + ID_W'(1);
`ifdef ARB_TIMEOUT_EN
                    w_hold_next  = '0;
`endif
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_next = RELEASE;
                    w_gnt_next   = '0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (w_hold_inc == 8'(MAX_HOLD)) begin
                    w_state_next   = RELEASE;
                    w_gnt_next     = '0;
                    w_timeout_next = 1'b1;
                end
                w_hold_next = w_hold_inc;
`endif
            end
            RELEASE: begin
                w_state_next = IDLE;
                w_gnt_next   = '0;
            end
            default: begin
                w_state_next = IDLE;
                w_gnt_next   = '0;
            end
        endcase
    end

    // State, pointer and output registers; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_gnt       <= w_gnt_next;
            r_gnt_id    <= w_gnt_id_next;
            r_gnt_valid <= |w_gnt_next;
            r_timeout   <= w_timeout_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Grant hold counter: cleared on grant entry, counts each GRANT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold <= '0;
        end else begin
            r_hold <= w_hold_next;
        end
    end
`endif

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_arbiter_8req.sv
// Directed self-checking bench for arbiter_8req (honours ARB_TIMEOUT_EN if defined).
module tb_arbiter_8req;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [7:0] g;
    } exp_t;

    exp_t sb[$];

    arbiter_8req #(.MAX_HOLD(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] idx_of(input logic [7:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (g[k]) r = 3'(k);
        end
        return r;
    endfunction

    task automatic push(input string tag, input logic [7:0] g);
        exp_t e;
        e.tag = tag;
        e.g   = g;
        sb.push_back(e);
    endtask

    // Pop one expected grant and compare all grant outputs against it.
    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".gnt"}, 32'(gnt), 32'(e.g));
            chk({e.tag, ".id"}, 32'(gnt_id), 32'(idx_of(e.g)));
            chk({e.tag, ".valid"}, 32'(gnt_valid), 32'(e.g != 8'h00));
        end
    endtask

    // Expect one tick, then compare.
    task automatic step(input string tag, input logic [7:0] g);
        push(tag, g);
        tick();
        compare();
    endtask

    // Clock until a grant appears (bounded), returning the number of edges taken.
    task automatic wait_grant(input int budget, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while ((gnt == 8'h00) && (edges < budget));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int edges;
        logic [7:0] exp_g;

        reset = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        tick();
        tick();

        // Reset state
        push("reset", 8'h00);
        compare();
        chk("reset.timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        step("idle_noreq", 8'h00);

        // Single request right after reset
        req = 8'h01;
        step("first_grant", 8'h01);
        done = 1'b1;
        step("first_release", 8'h00);
        done = 1'b0;
        req  = 8'h00;
        step("first_idle", 8'h00);

        // All requesting: rotation 0..7,0 with dead cycles between grants
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_g = 8'h01 << (k % 8);
            push($sformatf("rot%0d", k), exp_g);
            wait_grant(6, edges);
            compare();
            if (k != 0) chk($sformatf("rot%0d.gap", k), 32'(edges > 1), 32'd1);
            done = 1'b1;
            step($sformatf("rot%0d_rel", k), 8'h00);
            done = 1'b0;
        end
        req = 8'h00;
        tick();

        // Pointer wrap: ptr=7 with req 0x81
        do_reset();
        req = 8'h40;
        step("ptr7_setup", 8'h40);
        done = 1'b1;
        step("ptr7_setup_rel", 8'h00);
        done = 1'b0;
        req  = 8'h81;
        step("wrap_idle", 8'h00);
        step("wrap_hi", 8'h80);
        done = 1'b1;
        step("wrap_hi_rel", 8'h00);
        done = 1'b0;
        step("wrap_idle2", 8'h00);
        step("wrap_lo", 8'h01);

        // Owner holds request with no done
        req = 8'h01;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 15; k++) tick();
        push("hold_16th", 8'h01);
        compare();
        chk("hold_16th.timeout", 32'(timeout), 32'd0);
        step("hold_revoked", 8'h00);
        chk("timeout_pulse", 32'(timeout), 32'd1);
        req = 8'h00;
        step("timeout_after", 8'h00);
        chk("timeout_cleared", 32'(timeout), 32'd0);
`else
        for (int k = 0; k < 19; k++) tick();
        push("hold_long", 8'h01);
        compare();
        chk("hold_long.timeout", 32'(timeout), 32'd0);
        done = 1'b1;
        step("hold_long_rel", 8'h00);
        done = 1'b0;
        req  = 8'h00;
        step("hold_long_idle", 8'h00);
`endif

        // Asynchronous reset in the middle of a grant
        do_reset();
        req = 8'h10;
        step("pre_reset", 8'h10);
        #2;
        reset = 1'b1;
        #1;
        push("async_reset", 8'h00);
        compare();
        reset = 1'b0;
        step("post_reset_grant", 8'h10);
        #2;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        req = 8'h84;
        step("post_reset_ptr0", 8'h04);

        // done and owner request drop together, then done in IDLE
        do_reset();
        req = 8'h02;
        step("dual_grant", 8'h02);
        done = 1'b1;
        req  = 8'h00;
        step("dual_release", 8'h00);
        chk("dual_release.timeout", 32'(timeout), 32'd0);
        done = 1'b0;
        step("dual_idle", 8'h00);
        done = 1'b1;
        step("done_in_idle", 8'h00);
        done = 1'b0;
        step("done_in_idle2", 8'h00);
        chk("no_timeout_idle", 32'(timeout), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
